seg_scan_driver: RTL and testbench

- Time-multiplexed driver for the 8-digit common-anode seven-segment display on the board.
- Sits directly downstream of the timer/counter blocks: consumes their packed 32-bit nibble word (digit 7 = data[31:28] ... digit 0 = data[3:0]) and drives the an/seg pins.
- Snapshots the input once per frame so a digit never shows a half-updated value, and supports per-digit enables.

---
 rtl/seg_scan_driver_pkg.sv | 33 +++
 rtl/seg_scan_prescaler.sv | 27 ++
 rtl/seg_scan_driver.sv | 73 +++++++
 tb/tb_seg_scan_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_driver_pkg.sv
// seg_pkg: shared constants and the hex-to-segment table for the
// seven-segment display users (active-low segments, {g,f,e,d,c,b,a}).
package seg_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam logic [6:0]  SEG_BLANK  = 7'h7F;
   localparam logic [7:0]  AN_NONE    = 8'hFF;

   // Active-low segment pattern for one hex nibble
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0: pat = 7'h40;
         4'h1: pat = 7'h79;
         4'h2: pat = 7'h24;
         4'h3: pat = 7'h30;
         4'h4: pat = 7'h19;
         4'h5: pat = 7'h12;
         4'h6: pat = 7'h02;
         4'h7: pat = 7'h78;
         4'h8: pat = 7'h00;
         4'h9: pat = 7'h10;
         4'hA: pat = 7'h08;
         4'hB: pat = 7'h03;
         4'hC: pat = 7'h46;
         4'hD: pat = 7'h21;
         4'hE: pat = 7'h06;
         default: pat = 7'h0E;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg_scan_prescaler.sv
// seg_scan_prescaler: free-running 0..SCAN_DIV-1 counter; tick marks the
// last cycle of each digit slot.
module seg_scan_prescaler #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

   // Slot counter, wraps to zero on tick
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for the 8-digit common-anode
// seven-segment display. Input word and enables are snapshotted once per
// frame (at the 7->0 index wrap) so a frame never shows torn data.
// Optional: define SEG_LZ_BLANK_EN for leading-zero suppression.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data,
   input  logic [7:0]  digit_en,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        frame_start
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

   logic             tick;
   logic [IDX_W-1:0] idx;
   logic [31:0]      data_q;
   logic [7:0]       en_q;
   logic             lit;
   logic [3:0]       nib;
   logic [7:0]       an_d;
   logic [6:0]       seg_d;

   seg_scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Decode the current slot into next anode/segment values
   always_comb begin
      nib = data_q[{idx, 2'b00} +: 4];
      lit = en_q[idx];
`ifdef SEG_LZ_BLANK_EN
      // Digit i>=1 goes dark when it and every higher nibble are zero
      if ((idx != '0) && ((data_q >> {idx, 2'b00}) == 32'h0))
         lit = 1'b0;
`endif
      an_d  = lit ? ~(8'b1 << idx) : AN_NONE;
      seg_d = lit ? hex_to_seg(nib) : SEG_BLANK;
   end

   // Digit index, frame capture, and registered display outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx         <= '0;
         data_q      <= '0;
         en_q        <= '0;
         an          <= AN_NONE;
         seg         <= SEG_BLANK;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (tick) begin
            idx <= idx + IDX_W'(1);
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
               data_q      <= data;
               en_q        <= digit_en;
               frame_start <= 1'b1;
            end
         end
         an  <= an_d;
         seg <= seg_d;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed tests for seg_scan_driver with SCAN_DIV=4
// (main instance) and SCAN_DIV=2 (prescaler boundary instance).
module tb_seg_scan_driver;

   logic        clk;
   logic        rst, rst2;
   logic [31:0] data, data2;
   logic [7:0]  digit_en, en2;
   logic [7:0]  an, an2;
   logic [6:0]  seg, seg2;
   logic        frame_start, frame_start2;

   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] cur_d;
   logic [7:0]  cur_e;

   seg_scan_driver #(.SCAN_DIV(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .data        (data),
      .digit_en    (digit_en),
      .an          (an),
      .seg         (seg),
      .frame_start (frame_start)
   );

   seg_scan_driver #(.SCAN_DIV(2)) dut2 (
      .clk         (clk),
      .rst         (rst2),
      .data        (data2),
      .digit_en    (en2),
      .an          (an2),
      .seg         (seg2),
      .frame_start (frame_start2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] exp_seg(input logic [3:0] n);
      logic [6:0] t [16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[n];
   endfunction

   function automatic logic exp_lit(input logic [31:0] d, input logic [7:0] e,
                                    input int unsigned k);
      logic r;
      r = e[k];
`ifdef SEG_LZ_BLANK_EN
      if (k != 0 && (d >> (4 * k)) == 32'h0) r = 1'b0;
`endif
      return r;
   endfunction

   function automatic logic [7:0] exp_an(input logic [31:0] d, input logic [7:0] e,
                                         input int unsigned k);
      logic [7:0] a;
      a = 8'hFF;
      if (exp_lit(d, e, k)) a[k] = 1'b0;
      return a;
   endfunction

   function automatic logic [6:0] exp_sg(input logic [31:0] d, input logic [7:0] e,
                                         input int unsigned k);
      logic [3:0] n;
      n = d[4*k +: 4];
      return exp_lit(d, e, k) ? exp_seg(n) : 7'h7F;
   endfunction

   // Entry: at a negedge where frame_start is high (data cur_d/cur_e just
   // captured). Checks one full frame and ends at the next frame_start.
   task automatic run_frame(input string name, input logic [31:0] nd,
                            input logic [7:0] ne, input logic mid,
                            input logic [31:0] md);
      int unsigned k;
      data     = nd;
      digit_en = ne;
      for (int unsigned i = 0; i < 32; i++) begin
         if (mid && i == 12) data = md;
         @(negedge clk);
         k = i / 4;
         n_checks++;
         if (an !== exp_an(cur_d, cur_e, k)) begin
            n_fail++;
            $display("FAIL %s an slot%0d cyc%0d: got %h want %h", name, k, i, an,
                     exp_an(cur_d, cur_e, k));
         end
         n_checks++;
         if (seg !== exp_sg(cur_d, cur_e, k)) begin
            n_fail++;
            $display("FAIL %s seg slot%0d cyc%0d: got %h want %h", name, k, i, seg,
                     exp_sg(cur_d, cur_e, k));
         end
         n_checks++;
         if (frame_start !== (i == 31)) begin
            n_fail++;
            $display("FAIL %s frame_start cyc%0d: got %b want %b", name, i,
                     frame_start, (i == 31));
         end
      end
      cur_d = mid ? md : nd;
      cur_e = ne;
   endtask

   // After reset release at a negedge: dark display, first pulse 32 cycles later
   task automatic wait_first_frame(input string name);
      for (int unsigned i = 1; i <= 32; i++) begin
         @(negedge clk);
         n_checks++;
         if (frame_start !== (i == 32)) begin
            n_fail++;
            $display("FAIL %s frame_start cyc%0d: got %b want %b", name, i,
                     frame_start, (i == 32));
         end
         n_checks++;
         if (an !== 8'hFF || seg !== 7'h7F) begin
            n_fail++;
            $display("FAIL %s dark cyc%0d: got an=%h seg=%h want an=ff seg=7f",
                     name, i, an, seg);
         end
      end
      cur_d = data;
      cur_e = digit_en;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (an !== 8'hFF || seg !== 7'h7F || frame_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got an=%h seg=%h fs=%b want an=ff seg=7f fs=0",
                  an, seg, frame_start);
      end
      rst = 1'b0;
      wait_first_frame("reset_release");
   endtask

   task automatic test_basic_scan;
      run_frame("basic0", 32'h0123_4567, 8'hFF, 1'b0, 32'h0);
      run_frame("basic1", 32'h0123_4567, 8'hFF, 1'b0, 32'h0);
   endtask

   task automatic test_tear_free;
      run_frame("tear_old", 32'h0123_4567, 8'hFF, 1'b1, 32'hFFFF_FFFF);
      run_frame("tear_new", 32'h0123_4567, 8'h05, 1'b0, 32'h0);
   endtask

   task automatic test_digit_enable;
      run_frame("digit_en", 32'h0000_0000, 8'hFF, 1'b0, 32'h0);
   endtask

   task automatic test_lz_blank;
      run_frame("lz_zero", 32'h0010_0000, 8'hFF, 1'b0, 32'h0);
      run_frame("lz_one", 32'h0123_4567, 8'hFF, 1'b0, 32'h0);
   endtask

   task automatic test_reset_mid;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (an !== 8'hFF || seg !== 7'h7F || frame_start !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got an=%h seg=%h fs=%b want an=ff seg=7f fs=0",
                  an, seg, frame_start);
      end
      @(negedge clk);
      rst = 1'b0;
      wait_first_frame("reset_mid_release");
      run_frame("after_reset", 32'h0123_4567, 8'hFF, 1'b0, 32'h0);
   endtask

   task automatic test_prescaler_boundary;
      int unsigned k;
      data2 = 32'h89AB_CDEF;
      en2   = 8'hFF;
      @(negedge clk);
      rst2 = 1'b0;
      for (int unsigned i = 1; i <= 16; i++) begin
         @(negedge clk);
         n_checks++;
         if (frame_start2 !== (i == 16)) begin
            n_fail++;
            $display("FAIL div2_first_fs cyc%0d: got %b want %b", i, frame_start2,
                     (i == 16));
         end
      end
      for (int unsigned f = 0; f < 2; f++) begin
         for (int unsigned i = 0; i < 16; i++) begin
            @(negedge clk);
            k = i / 2;
            n_checks++;
            if (an2 !== exp_an(32'h89AB_CDEF, 8'hFF, k) ||
                seg2 !== exp_sg(32'h89AB_CDEF, 8'hFF, k)) begin
               n_fail++;
               $display("FAIL div2_scan f%0d cyc%0d: got an=%h seg=%h want an=%h seg=%h",
                        f, i, an2, seg2, exp_an(32'h89AB_CDEF, 8'hFF, k),
                        exp_sg(32'h89AB_CDEF, 8'hFF, k));
            end
            n_checks++;
            if (frame_start2 !== (i == 15)) begin
               n_fail++;
               $display("FAIL div2_fs f%0d cyc%0d: got %b want %b", f, i,
                        frame_start2, (i == 15));
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      rst2     = 1'b1;
      data     = 32'h0123_4567;
      digit_en = 8'hFF;
      data2    = 32'h0;
      en2      = 8'h0;
      cur_d    = 32'h0;
      cur_e    = 8'h0;
      test_reset();
      test_basic_scan();
      test_tear_free();
      test_digit_enable();
      test_lz_blank();
      test_reset_mid();
      test_prescaler_boundary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
